// File: rtl/spi_block_packer_pkg.sv
// spi_block_packer_pkg: shared widths, fill default and RX/TX state encodings for the SPI/AES packer
package spi_block_packer_pkg;
  localparam int BYTE_W = 8;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W = AES_BLOCK_BYTES * BYTE_W;
  localparam logic [BYTE_W-1:0] DEF_FILL_BYTE = 8'h00;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_e;
  typedef enum logic {TX_EMPTY, TX_LOADED} tx_state_e;
endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: one-cycle pulse on a rising level, history register cleared by async active-low reset
module spi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic prev_q, prev_d;
  // next history is simply the current level
  always_comb prev_d = d;
  // history register; cleared so a level already high right after reset still counts as a rise
  always_ff @(posedge clk or negedge reset)
    if (!reset) prev_q <= 1'b0;
    else prev_q <= prev_d;
  assign pulse = d & ~prev_q;
endmodule

// File: rtl/spi_block_packer.sv
// spi_block_packer: packs SPI bytes into AES blocks and serializes AES results back, MSB byte first; SPI_PACKER_CS_ABORT_EN enables cs-rise abort of partial frames
module spi_block_packer
  import spi_block_packer_pkg::*;
#(
  parameter int                BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter logic [BYTE_W-1:0] FILL_BYTE   = DEF_FILL_BYTE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byte_done,
  input  logic [BYTE_W-1:0]             rx_byte,
  output logic [BYTE_W-1:0]             tx_byte,
  input  logic                          cs,
  output logic [BLOCK_BYTES*BYTE_W-1:0] block_data,
  output logic                          block_valid,
  input  logic                          block_ready,
  input  logic [BLOCK_BYTES*BYTE_W-1:0] result_data,
  input  logic                          result_valid,
  output logic                          result_ready,
  output logic                          overrun,
  output logic                          underrun,
  input  logic                          clear_flags
);
  localparam int W = BLOCK_BYTES * BYTE_W;
  localparam int IW = BLOCK_BYTES > 1 ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BLOCK_BYTES - 1);

  logic ev, abort, ovr_set, und_set;
  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [IW-1:0] count_q, count_d, idx_q, idx_d;
  logic [W-1:0] block_q, block_d, shifted;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] res_q, res_d;
  logic overrun_q, overrun_d, underrun_q, underrun_d;

  spi_edge_detect u_byte_edge (.clk(clk), .reset(reset), .d(byte_done), .pulse(ev));

`ifdef SPI_PACKER_CS_ABORT_EN
  spi_edge_detect u_cs_edge (.clk(clk), .reset(reset), .d(cs), .pulse(abort));
`else
  logic unused_cs;
  assign unused_cs = cs;
  assign abort = 1'b0;
`endif

  assign shifted = {block_q[W-BYTE_W-1:0], rx_byte};

  // RX: shift bytes in until a block is full, then hold it until the core takes it
  always_comb begin
    rx_state_d = rx_state_q;
    count_d = count_q;
    block_d = block_q;
    ovr_set = 1'b0;
    if (rx_state_q == RX_COLLECT) begin
      if (ev) begin
        block_d = shifted;
        count_d = count_q == LAST ? '0 : count_q + IW'(1);
        rx_state_d = count_q == LAST ? RX_HOLD : RX_COLLECT;
      end
      if (abort && rx_state_d == RX_COLLECT) count_d = '0;
    end else if (block_ready) begin
      rx_state_d = RX_COLLECT;
      if (ev) begin
        block_d = shifted;
        count_d = IW'(1);
      end
    end else begin
      ovr_set = ev;
    end
  end

  // RX state, byte count and block shift register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_state_q <= RX_COLLECT;
      count_q <= '0;
      block_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      count_q <= count_d;
      block_q <= block_d;
    end

  // TX: load a result when empty, step through its bytes one per event
  always_comb begin
    tx_state_d = tx_state_q;
    res_d = res_q;
    idx_d = idx_q;
    und_set = 1'b0;
    if (tx_state_q == TX_EMPTY) begin
      und_set = ev;
      if (result_valid) begin
        res_d = result_data;
        idx_d = '0;
        tx_state_d = TX_LOADED;
      end
    end else begin
      if (ev) begin
        idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        tx_state_d = idx_q == LAST ? TX_EMPTY : TX_LOADED;
      end
      if (abort) idx_d = '0;
    end
  end

  // TX state, loaded result and byte index
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state_q <= TX_EMPTY;
      res_q <= '0;
      idx_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      res_q <= res_d;
      idx_q <= idx_d;
    end

  // sticky error flags; a clear wins over a same-cycle set
  always_comb begin
    overrun_d = clear_flags ? 1'b0 : overrun_q | ovr_set;
    underrun_d = clear_flags ? 1'b0 : underrun_q | und_set;
  end

  // error flag registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overrun_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      underrun_q <= underrun_d;
    end

  assign block_data = block_q;
  assign block_valid = rx_state_q == RX_HOLD;
  assign result_ready = tx_state_q == TX_EMPTY;
  assign tx_byte = tx_state_q == TX_LOADED ? res_q[LAST - idx_q] : FILL_BYTE;
  assign overrun = overrun_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_spi_block_packer.sv
// tb_spi_block_packer: table-driven, directed and randomized self-checking bench for spi_block_packer
module tb_spi_block_packer;
  logic clk = 1'b0;
  logic reset, bd, cs, br, rv, clr;
  logic [7:0] rb, tx;
  logic [127:0] blk, rdata;
  logic bv, rr, ovr, und;
  int checks = 0, errors = 0;

  spi_block_packer dut (
    .clk(clk), .reset(reset), .byte_done(bd), .rx_byte(rb), .tx_byte(tx), .cs(cs),
    .block_data(blk), .block_valid(bv), .block_ready(br), .result_data(rdata),
    .result_valid(rv), .result_ready(rr), .overrun(ovr), .underrun(und), .clear_flags(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit bd; logic [7:0] rb; bit br; bit rv;
    bit e_valid; bit e_rr; logic [7:0] e_tx; bit c_blk;
  } vec_t;
  vec_t tv[$];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input bit v, input bit r, input bit o, input bit u, input logic [7:0] t);
    chk(nm, 128'({bv, rr, ovr, und, tx}), 128'({v, r, o, u, t}));
  endtask

  task automatic send(input logic [7:0] b);
    bd = 1'b1; rb = b; cyc();
    bd = 1'b0; cyc();
  endtask

  task automatic pulse_br();
    br = 1'b1; cyc(); br = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  // behavioural reference: partial block and pending result bytes as queues
  bit m_prev, m_cprev, m_hold, m_ovr, m_und;
  logic [7:0] rxq[$], txq[$], txfull[$];
  logic [127:0] m_blk;

  task automatic model_reset();
    m_prev = 0; m_cprev = 0; m_hold = 0; m_ovr = 0; m_und = 0;
    rxq.delete(); txq.delete(); txfull.delete(); m_blk = '0;
  endtask

  task automatic model_step();
    bit ev, cr, was_hold, was_loaded;
    ev = bd && !m_prev; m_prev = bd;
    cr = cs && !m_cprev; m_cprev = cs;
    was_hold = m_hold;
    was_loaded = txq.size() != 0;
    if (!was_hold) begin
      if (ev) rxq.push_back(rb);
      if (rxq.size() == 16) begin
        m_blk = '0;
        foreach (rxq[i]) m_blk = (m_blk << 8) | 128'(rxq[i]);
        rxq.delete();
        m_hold = 1;
      end
    end else if (br) begin
      m_hold = 0;
      if (ev) rxq.push_back(rb);
    end else if (ev) m_ovr = 1;
    if (!was_loaded) begin
      if (ev) m_und = 1;
      if (rv) begin
        for (int i = 0; i < 16; i++) txq.push_back(rdata[127-8*i -: 8]);
        txfull = txq;
      end
    end else if (ev) void'(txq.pop_front());
`ifdef SPI_PACKER_CS_ABORT_EN
    if (cr) begin
      if (!was_hold) rxq.delete();
      if (was_loaded && txq.size() != 0) txq = txfull;
    end
`else
    if (cr) m_cprev = 1;
`endif
    if (clr) begin m_ovr = 0; m_und = 0; end
  endtask

  initial begin
    reset = 0; bd = 0; cs = 0; br = 0; rv = 0; clr = 0; rb = 0; rdata = '0;
    cyc(); cyc();
    reset = 1;
    chk_ctl("reset ctl", 0, 1, 0, 0, 8'h00);
    chk("reset block", blk, '0);

    // tests 1+2: result load then 16 events feeding both paths
    rdata = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b0});
    for (int i = 0; i < 16; i++) begin
      tv.push_back('{1'b1, 8'(i), 1'b1, 1'b0, i == 15, i == 15, (i == 15) ? 8'h00 : 8'(8'hA1 + i), i == 15});
      tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, i == 15, (i == 15) ? 8'h00 : 8'(8'hA1 + i), 1'b0});
    end
    foreach (tv[i]) begin
      bd = tv[i].bd; rb = tv[i].rb; br = tv[i].br; rv = tv[i].rv;
      cyc();
      chk($sformatf("vec%0d valid/ready/tx", i), 128'({bv, rr, tx}), 128'({tv[i].e_valid, tv[i].e_rr, tv[i].e_tx}));
      if (tv[i].c_blk) chk($sformatf("vec%0d block", i), blk, 128'h000102030405060708090A0B0C0D0E0F);
    end
    br = 0; rv = 0;

    // tests 3+4: held block, overrun, underrun, clear priority
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    chk_ctl("t4 underrun full", 1, 1, 0, 1, 8'h00);
    chk("t3 block", blk, 128'h101112131415161718191A1B1C1D1E1F);
    send(8'hFF);
    chk_ctl("t3 overrun", 1, 1, 1, 1, 8'h00);
    chk("t3 block frozen", blk, 128'h101112131415161718191A1B1C1D1E1F);
    pulse_clr();
    chk_ctl("t3 clear", 1, 1, 0, 0, 8'h00);
    bd = 1; rb = 8'hEE; clr = 1; cyc();
    chk_ctl("t3 clear priority", 1, 1, 0, 0, 8'h00);
    bd = 0; clr = 0; cyc();

    // test 5: handshake coinciding with an event keeps the byte
    bd = 1; rb = 8'h5A; br = 1; cyc();
    chk_ctl("t5 handshake", 0, 1, 0, 1, 8'h00);
    bd = 0; br = 0; cyc();
    for (int i = 0; i < 15; i++) send(8'(8'h61 + i));
    chk_ctl("t5 full", 1, 1, 0, 1, 8'h00);
    chk("t5 block", blk, 128'h5A6162636465666768696A6B6C6D6E6F);
    pulse_br(); cyc();
    chk_ctl("t5 released", 0, 1, 0, 1, 8'h00);
    pulse_clr();

    // test 6: async reset mid-block, long byte_done high
    rdata = 128'h00112233445566778899AABBCCDDEEFF;
    rv = 1; cyc(); rv = 0;
    chk_ctl("t6 loaded", 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) send(8'(8'h20 + i));
    chk_ctl("t6 mid tx", 0, 0, 0, 0, 8'h77);
    #2 reset = 0;
    #1 chk_ctl("t6 async reset", 0, 1, 0, 0, 8'h00);
    chk("t6 reset block", blk, '0);
    @(negedge clk) reset = 1;
    bd = 1; rb = 8'h80; cyc();
    rb = 8'h99; cyc(); cyc();
    bd = 0; cyc();
    for (int i = 0; i < 15; i++) send(8'(8'h81 + i));
    chk_ctl("t6 clean block", 1, 1, 0, 1, 8'h00);
    chk("t6 block", blk, 128'h808182838485868788898A8B8C8D8E8F);
    pulse_br(); pulse_clr();

`ifdef SPI_PACKER_CS_ABORT_EN
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
    cs = 1; cyc(); cs = 0; cyc();
    for (int i = 0; i < 16; i++) send(8'(8'hD0 + i));
    chk_ctl("cs abort full", 1, 1, 0, 1, 8'h00);
    chk("cs abort block", blk, 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);
    pulse_br(); pulse_clr();
    rdata = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    rv = 1; cyc(); rv = 0;
    for (int i = 0; i < 3; i++) send(8'h00);
    chk_ctl("cs tx before", 0, 0, 0, 0, 8'hA3);
    cs = 1; cyc();
    chk_ctl("cs tx rewind", 0, 0, 0, 0, 8'hA0);
    cs = 0; cyc();
`else
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
    cs = 1; cyc(); cs = 0; cyc();
    for (int i = 0; i < 11; i++) send(8'(8'hC5 + i));
    chk_ctl("cs ignored full", 1, 1, 0, 1, 8'h00);
    chk("cs ignored block", blk, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    pulse_br(); pulse_clr();
    rdata = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    rv = 1; cyc(); rv = 0;
    for (int i = 0; i < 3; i++) send(8'h00);
    cs = 1; cyc();
    chk_ctl("cs ignored tx", 0, 0, 0, 0, 8'hA3);
    cs = 0; cyc();
`endif

    // randomized run against the queue model
    reset = 0; bd = 0; cs = 0; br = 0; rv = 0; clr = 0;
    cyc(); cyc();
    reset = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bd = 1'($urandom_range(0, 1));
      rb = 8'($urandom);
      br = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      cs = ($urandom_range(0, 7) == 0) ? ~cs : cs;
      rdata = {$urandom, $urandom, $urandom, $urandom};
      model_step();
      cyc();
      chk($sformatf("rand%0d ctl", n), 128'({bv, rr, ovr, und, tx}),
          128'({m_hold, txq.size() == 0, m_ovr, m_und, (txq.size() != 0) ? txq[0] : 8'h00}));
      if (m_hold && bv) chk($sformatf("rand%0d block", n), blk, m_blk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
